// File: rtl/mopshub_tb_pkg.sv
// Shared types and default timing for the MOPSHUB test-phase sequencer.
package mopshub_tb_pkg;

  // Phase encoding; also driven out on the phase port.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    TRIM    = 4'd1,
    WAIT_SO = 4'd2,
    RX      = 4'd3,
    ENDW    = 4'd4,
    GAP     = 4'd5,
    TX      = 4'd6,
    ADV     = 4'd7,
    DONE    = 4'd8,
    TMO     = 4'd9
  } seq_state_t;

  localparam logic DEF_TRIM_EN        = 1'b1;
  localparam logic DEF_ADV_EN         = 1'b0;
  localparam int   DEF_ENDWAIT_CYCLES = 4;
  localparam int   DEF_GAP_CYCLES     = 120;
  localparam int   DEF_TIMEOUT_CYCLES = 2**20;
  localparam int   DEF_CNT_W          = 24;

  // Watchdog / phase timer width; wide enough for any sensible timeout or gap.
  localparam int   WD_W               = 32;

  // Phases guarded by the watchdog (waiting on an external completion pulse).
  function automatic logic is_watched(input seq_state_t s);
    logic w;
    case (s)
      TRIM, RX, TX, ADV: w = 1'b1;
      default:           w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mopshub_test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps.
module seq_sat_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk_40_m,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled, stop at all-ones, clear has priority over counting.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mopshub_test_sequencer.sv
// Orders the MOPSHUB bench test phases: trim, sign-on wait, RX, endwait
// strobe, gap, TX, optional custom message. One shared timer serves as the
// per-phase watchdog and as the ENDW/GAP duration timer.
module mopshub_test_sequencer
  import mopshub_tb_pkg::*;
#(
  parameter logic TRIM_EN        = DEF_TRIM_EN,
  parameter logic ADV_EN         = DEF_ADV_EN,
  parameter int   ENDWAIT_CYCLES = DEF_ENDWAIT_CYCLES,
  parameter int   GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int   CNT_W          = DEF_CNT_W
) (
  input  logic             clk_40_m,
  input  logic             rst,
  input  logic             end_power_init,
  input  logic             sign_on_sig,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             costum_msg_end,
  output logic             osc_auto_trim_mopshub,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic             endwait_all,
  output logic [3:0]       phase,
  output logic             seq_done,
  output logic             seq_timeout,
  output logic [CNT_W-1:0] rx_cycles,
  output logic [CNT_W-1:0] tx_cycles
);

  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] ENDW_LAST = WD_W'(ENDWAIT_CYCLES - 1);
  localparam logic [WD_W-1:0] GAP_LAST  = WD_W'(GAP_CYCLES - 1);

  seq_state_t      r_state;
  seq_state_t      w_next_state;
  logic [WD_W-1:0] w_wd_cnt;
  logic            w_state_change;
  logic            w_wd_expired;
  logic            r_trim;
  logic            r_test_rx;
  logic            r_test_tx;
  logic            r_test_adv;
  logic            r_endwait;
  logic            r_done;
  logic            r_timeout;

  assign w_state_change = (w_next_state != r_state);
  assign w_wd_expired   = is_watched(r_state) && (w_wd_cnt == WD_LAST);

  // Next-state logic; completion inputs are checked before watchdog expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (TRIM_EN) w_next_state = TRIM;
        else         w_next_state = WAIT_SO;
      end
      TRIM: begin
        if (end_power_init)    w_next_state = WAIT_SO;
        else if (w_wd_expired) w_next_state = TMO;
        else                   w_next_state = r_state;
      end
      WAIT_SO: begin
        if (sign_on_sig) w_next_state = RX;
        else             w_next_state = r_state;
      end
      RX: begin
        if (test_rx_end)       w_next_state = ENDW;
        else if (w_wd_expired) w_next_state = TMO;
        else                   w_next_state = r_state;
      end
      ENDW: begin
        if (w_wd_cnt == ENDW_LAST) w_next_state = GAP;
        else                       w_next_state = r_state;
      end
      GAP: begin
        if (w_wd_cnt == GAP_LAST) w_next_state = TX;
        else                      w_next_state = r_state;
      end
      TX: begin
        if (test_tx_end) begin
          if (ADV_EN) w_next_state = ADV;
          else        w_next_state = DONE;
        end else if (w_wd_expired) begin
          w_next_state = TMO;
        end else begin
          w_next_state = r_state;
        end
      end
      ADV: begin
        if (costum_msg_end)    w_next_state = DONE;
        else if (w_wd_expired) w_next_state = TMO;
        else                   w_next_state = r_state;
      end
      DONE:    w_next_state = r_state;
      TMO:     w_next_state = r_state;
      default: w_next_state = IDLE;
    endcase
  end

  // State register plus registered Moore outputs decoded from the next state,
  // so each output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_trim     <= 1'b0;
      r_test_rx  <= 1'b0;
      r_test_tx  <= 1'b0;
      r_test_adv <= 1'b0;
      r_endwait  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_trim     <= (w_next_state == TRIM);
      r_test_rx  <= (w_next_state == RX);
      r_test_tx  <= (w_next_state == TX);
      r_test_adv <= (w_next_state == ADV);
      r_endwait  <= (w_next_state == ENDW);
      r_done     <= (w_next_state == DONE);
      r_timeout  <= (w_next_state == TMO);
    end
  end

  // Shared watchdog / ENDW-GAP timer, restarted on every state entry.
  seq_sat_counter #(.CNT_W(WD_W)) u_wd_cnt (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .i_clr    (w_state_change),
    .i_en     (1'b1),
    .o_cnt    (w_wd_cnt)
  );

  // Phase-duration counters: only reset clears them, so values hold afterwards.
  seq_sat_counter #(.CNT_W(CNT_W)) u_rx_cnt (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .i_clr    (1'b0),
    .i_en     (r_state == RX),
    .o_cnt    (rx_cycles)
  );

  seq_sat_counter #(.CNT_W(CNT_W)) u_tx_cnt (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .i_clr    (1'b0),
    .i_en     (r_state == TX),
    .o_cnt    (tx_cycles)
  );

  assign osc_auto_trim_mopshub = r_trim;
  assign test_rx               = r_test_rx;
  assign test_tx               = r_test_tx;
  assign test_advanced         = r_test_adv;
  assign endwait_all           = r_endwait;
  assign phase                 = r_state;
  assign seq_done              = r_done;
  assign seq_timeout           = r_timeout;

endmodule
